// File: rtl/crc_stream_engine.sv
// crc_stream_engine: parametrised streaming CRC generator/checker, folding BITS_PER_CYCLE bits per clock
module crc_stream_engine #(
  parameter int CRC_W = 8,
  parameter int DATA_W = 8,
  parameter int BITS_PER_CYCLE = 8,
  parameter logic [CRC_W-1:0] INIT = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter bit REFLECT_IN = 1'b0,
  parameter bit REFLECT_OUT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CRC_W-1:0]  poly,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_eof,
  output logic              crc_valid,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_zero,
  output logic              frame_err
);
  localparam int N = DATA_W / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, OPEN, BUSY} state_t;
  state_t state;
  logic [CRC_W-1:0] crc_q, poly_q, base, p_sel, crc_nxt;
  logic [DATA_W-1:0] word_q, src, rest;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [CW-1:0] cnt;
  logic eof_q, accept, load, last;

  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] c, input logic [BITS_PER_CYCLE-1:0] d,
                                             input logic [CRC_W-1:0] p);
    logic [CRC_W-1:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      fb = r[CRC_W-1] ^ (REFLECT_IN ? d[i] : d[BITS_PER_CYCLE-1-i]);
      r = (r << 1) ^ (fb ? p : '0);
    end
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] rev(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
    return r;
  endfunction

  // The remaining chunks of a word are shifted toward the consumed end so BUSY always folds the same slice
  always_comb begin
    accept = s_valid && s_ready;
    src = (state == BUSY) ? word_q : s_data;
    chunk = REFLECT_IN ? src[BITS_PER_CYCLE-1:0] : src[DATA_W-1 -: BITS_PER_CYCLE];
    rest = REFLECT_IN ? src >> BITS_PER_CYCLE : src << BITS_PER_CYCLE;
    load = accept && s_sof;
    base = load ? INIT : crc_q;
    p_sel = load ? poly : poly_q;
    crc_nxt = fold(base, chunk, p_sel);
    last = (state == BUSY) ? (cnt == CW'(N - 1)) : (N == 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      crc_q <= INIT;
      poly_q <= '0;
      word_q <= '0;
      cnt <= '0;
      eof_q <= 1'b0;
      s_ready <= 1'b1;
      crc_valid <= 1'b0;
      crc_out <= '0;
      crc_zero <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      frame_err <= 1'b0;
      if (state == BUSY || (accept && (s_sof || state == OPEN))) begin
        crc_q <= crc_nxt;
        word_q <= rest;
        if (load) poly_q <= poly;
        if (state != BUSY) eof_q <= s_eof;
        cnt <= (state == BUSY) ? cnt + CW'(1) : CW'(1);
        if (!last) begin
          state <= BUSY;
          s_ready <= 1'b0;
        end else if ((state == BUSY) ? eof_q : s_eof) begin
          state <= IDLE;
          s_ready <= 1'b1;
          crc_valid <= 1'b1;
          crc_out <= (REFLECT_OUT ? rev(crc_nxt) : crc_nxt) ^ XOR_OUT;
          crc_zero <= (crc_nxt == '0);
        end else begin
          state <= OPEN;
          s_ready <= 1'b1;
        end
      end else if (accept) frame_err <= 1'b1;
    end
  end
endmodule
